// File: rtl/drec_sdram_port.sv
// drec_sdram_port
//   Buffers sample writes and single reads from a recorder front end and
//   serialises them onto a one-command-at-a-time SDRAM controller port.
//   Writes sit in a small FIFO and are always issued before a pending
//   read, so a read observes every write accepted before or with it.
//
// Optional feature macro: DREC_PORT_FWD_EN
//   When defined, a read whose address hits a buffered write (including a
//   write pushed in the same cycle) is answered from the FIFO two cycles
//   later, with no SDRAM command and no wait for the FIFO to drain.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   sdram_wr_data/addr/enable          one-cycle write request
//   sdram_rd_addr/enable               one-cycle read request
//   sdram_rd_data, sdram_rd_rdy        read result, one-cycle valid pulse
//   wr_full, rd_busy, err              FIFO full, read outstanding, sticky drop
//   cmd_valid/ready/we/addr/wdata      downstream command handshake
//   rsp_valid, rsp_data                downstream read response
//
// FSM states
//   state     | meaning
//   S_IDLE    | choose next command: buffered write first, then read
//   S_WRITE   | presenting FIFO head as write command
//   S_READ    | presenting latched read address as read command
//   S_RD_WAIT | read accepted downstream, waiting for rsp_valid

module drec_sdram_port #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sdram_wr_data,
    input  logic [ADDR_W-1:0] sdram_wr_addr,
    input  logic              sdram_wr_enable,
    input  logic [ADDR_W-1:0] sdram_rd_addr,
    input  logic              sdram_rd_enable,
    output logic [DATA_W-1:0] sdram_rd_data,
    output logic              sdram_rd_rdy,
    output logic              wr_full,
    output logic              rd_busy,
    output logic              err,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_READ    = 2'd2,
        S_RD_WAIT = 2'd3
    } state_t;

    state_t            state_q;
    logic              cmd_valid_q;
    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_rdy_q;
    logic              rd_busy_q;
    logic              rd_pend_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              err_q;
    logic              fwd_pend_q;
    logic [DATA_W-1:0] fwd_data_q;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              wr_full_q;

    logic              pop;
    logic              push;
    logic              wr_drop;
    logic              rd_accept;
    logic              rd_norm;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign pop       = (state_q == S_WRITE) && cmd_ready;
    assign push      = sdram_wr_enable && (!wr_full_q || pop);
    assign wr_drop   = sdram_wr_enable && wr_full_q && !pop;
    assign rd_accept = sdram_rd_enable && !rd_busy_q;
    assign rd_norm   = rd_accept && !fwd_hit;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

`ifdef DREC_PORT_FWD_EN
    // Scan oldest to youngest so the last hit wins; a same-cycle push is
    // younger than anything already buffered.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) &&
                (fifo_addr_q[rd_ptr_q + PTR_W'(k)] == sdram_rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[rd_ptr_q + PTR_W'(k)];
            end
        end
        if (push && (sdram_wr_addr == sdram_rd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = sdram_wr_data;
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= sdram_wr_addr;
            fifo_data_q[wr_ptr_q] <= sdram_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_full_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q   <= count_d;
            wr_full_q <= (count_d == CNT_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_rdy_q    <= 1'b0;
            rd_busy_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            err_q       <= 1'b0;
            fwd_pend_q  <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            rd_rdy_q <= 1'b0;

            if (wr_drop || (sdram_rd_enable && rd_busy_q)) begin
                err_q <= 1'b1;
            end

            if (rd_accept) begin
                rd_busy_q <= 1'b1;
                rd_addr_q <= sdram_rd_addr;
            end
            if (rd_norm) begin
                rd_pend_q <= 1'b1;
            end

            // Forwarded reads: one cycle to capture, one to present.
            fwd_pend_q <= rd_accept && fwd_hit;
            if (rd_accept && fwd_hit) begin
                fwd_data_q <= fwd_data;
            end
            if (fwd_pend_q) begin
                rd_rdy_q  <= 1'b1;
                rd_data_q <= fwd_data_q;
                rd_busy_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q     <= S_WRITE;
                        cmd_valid_q <= 1'b1;
                        cmd_we_q    <= 1'b1;
                        cmd_addr_q  <= fifo_addr_q[rd_ptr_q];
                        cmd_wdata_q <= fifo_data_q[rd_ptr_q];
                    end else if (rd_pend_q) begin
                        state_q     <= S_READ;
                        cmd_valid_q <= 1'b1;
                        cmd_we_q    <= 1'b0;
                        cmd_addr_q  <= rd_addr_q;
                        rd_pend_q   <= 1'b0;
                    end else if (push) begin
                        // Empty FIFO: the incoming write is the head, issue it directly.
                        state_q     <= S_WRITE;
                        cmd_valid_q <= 1'b1;
                        cmd_we_q    <= 1'b1;
                        cmd_addr_q  <= sdram_wr_addr;
                        cmd_wdata_q <= sdram_wr_data;
                    end else if (rd_norm) begin
                        state_q     <= S_READ;
                        cmd_valid_q <= 1'b1;
                        cmd_we_q    <= 1'b0;
                        cmd_addr_q  <= sdram_rd_addr;
                        rd_pend_q   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (cmd_ready) begin
                        state_q     <= S_IDLE;
                        cmd_valid_q <= 1'b0;
                        cmd_we_q    <= 1'b0;
                    end
                end
                S_READ: begin
                    if (cmd_ready) begin
                        state_q     <= S_RD_WAIT;
                        cmd_valid_q <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    if (rsp_valid) begin
                        state_q   <= S_IDLE;
                        rd_data_q <= rsp_data;
                        rd_rdy_q  <= 1'b1;
                        rd_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sdram_rd_data = rd_data_q;
    assign sdram_rd_rdy  = rd_rdy_q;
    assign wr_full       = wr_full_q;
    assign rd_busy       = rd_busy_q;
    assign err           = err_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_we        = cmd_we_q;
    assign cmd_addr      = cmd_addr_q;
    assign cmd_wdata     = cmd_wdata_q;

endmodule

// File: tb/tb_drec_sdram_port.sv
module tb_drec_sdram_port;

    logic        clk;
    logic        rst_n;
    logic [15:0] sdram_wr_data;
    logic [21:0] sdram_wr_addr;
    logic        sdram_wr_enable;
    logic [21:0] sdram_rd_addr;
    logic        sdram_rd_enable;
    logic [15:0] sdram_rd_data;
    logic        sdram_rd_rdy;
    logic        wr_full;
    logic        rd_busy;
    logic        err;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [21:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;

    drec_sdram_port #(.ADDR_W(22), .DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_wr_data   (sdram_wr_data),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_wr_enable (sdram_wr_enable),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_rd_enable (sdram_rd_enable),
        .sdram_rd_data   (sdram_rd_data),
        .sdram_rd_rdy    (sdram_rd_rdy),
        .wr_full         (wr_full),
        .rd_busy         (rd_busy),
        .err             (err),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_we          (cmd_we),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [21:0] addr;
        logic [15:0] data;
        int          dly;
        logic        exp_we;
        logic [21:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [21:0] addr;
        logic [15:0] data;
    } cmd_t;

    int tests = 0;
    int fails = 0;

    // Downstream SDRAM emulation and observation log
    cmd_t        cmd_log[$];
    logic [15:0] mem [logic [21:0]];
    int          rsp_cnt = 0;
    int          rsp_dly = 2;
    logic [15:0] rsp_val = '0;
    bit          spur_en = 1'b0;
    int          rdy_n = 0;
    logic [15:0] rdy_data = '0;
    int          rdy_cyc = 0;
    int          cyc = 0;

    // Reference model for the random phase
    logic [15:0] ref_mem [logic [21:0]];
    cmd_t        wq[$];
    logic [15:0] exp_rd[$];
    logic [15:0] last_rd = '0;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cmd_valid"}, 32'(cmd_valid), 32'h0);
        check({tag, " cmd_we"},    32'(cmd_we),    32'h0);
        check({tag, " cmd_addr"},  32'(cmd_addr),  32'h0);
        check({tag, " cmd_wdata"}, 32'(cmd_wdata), 32'h0);
        check({tag, " rd_data"},   32'(sdram_rd_data), 32'h0);
        check({tag, " rd_rdy"},    32'(sdram_rd_rdy),  32'h0);
        check({tag, " wr_full"},   32'(wr_full),   32'h0);
        check({tag, " rd_busy"},   32'(rd_busy),   32'h0);
        check({tag, " err"},       32'(err),       32'h0);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        sdram_wr_enable = 1'b0;
        sdram_rd_enable = 1'b0;
        sdram_wr_addr   = '0;
        sdram_wr_data   = '0;
        sdram_rd_addr   = '0;
        rsp_valid       = 1'b0;
        rsp_data        = '0;
        cmd_ready       = 1'b0;
        rsp_cnt         = 0;
        spur_en         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    // Emulates the SDRAM side for one cycle, logs what it sees, then advances.
    task automatic tick();
        rsp_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = rsp_val;
            end
        end else if (spur_en && ($urandom_range(0, 7) == 0)) begin
            rsp_valid = 1'b1;
            rsp_data  = 16'($urandom);
        end
        if (sdram_rd_rdy) begin
            rdy_n++;
            rdy_data = sdram_rd_data;
            rdy_cyc  = cyc;
        end
        if (cmd_valid && cmd_ready) begin
            cmd_t c;
            c.we   = cmd_we;
            c.addr = cmd_addr;
            c.data = cmd_wdata;
            cmd_log.push_back(c);
            if (cmd_we) begin
                mem[cmd_addr] = cmd_wdata;
            end else begin
                rsp_cnt = rsp_dly;
                rsp_val = mem.exists(cmd_addr) ? mem[cmd_addr] : 16'h0;
            end
        end
        step();
        cyc++;
    endtask

    // One random cycle: check outputs against the model, then drive new requests.
    task automatic rnd_cycle(input bit gen);
        logic [15:0] e;
        logic [21:0] a;
        logic [15:0] d;
        if (sdram_rd_rdy) begin
            if (exp_rd.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rnd_rdy: got rd_rdy with data 0x%0h, required no read outstanding", sdram_rd_data);
            end else begin
                e = exp_rd.pop_front();
                check("rnd_rd_data", 32'(sdram_rd_data), 32'(e));
                last_rd = e;
            end
        end else begin
            check("rnd_rd_hold", 32'(sdram_rd_data), 32'(last_rd));
        end
        cmd_ready = ($urandom_range(0, 3) != 0);
        if (cmd_valid && cmd_ready && cmd_we) begin
            if (wq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rnd_wcmd: got write cmd addr 0x%0h, required none pending", cmd_addr);
            end else begin
                cmd_t w;
                w = wq.pop_front();
                check("rnd_wcmd_addr", 32'(cmd_addr),  32'(w.addr));
                check("rnd_wcmd_data", 32'(cmd_wdata), 32'(w.data));
            end
        end
        rsp_dly = $urandom_range(1, 4);
        sdram_wr_enable = 1'b0;
        sdram_rd_enable = 1'b0;
        if (gen && !wr_full && !rd_busy && ($urandom_range(0, 1) == 1)) begin
            cmd_t w;
            a = 22'($urandom_range(0, 7));
            d = 16'($urandom);
            sdram_wr_enable = 1'b1;
            sdram_wr_addr   = a;
            sdram_wr_data   = d;
            w.we = 1'b1;
            w.addr = a;
            w.data = d;
            wq.push_back(w);
            ref_mem[a] = d;
        end
        if (gen && !rd_busy && ($urandom_range(0, 3) == 0)) begin
            a = 22'($urandom_range(0, 7));
            sdram_rd_enable = 1'b1;
            sdram_rd_addr   = a;
            exp_rd.push_back(ref_mem.exists(a) ? ref_mem[a] : 16'h0);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 22'h000010, 16'hA5A5, 0, 1'b1, 22'h000010, 16'hA5A5};
        vecs[1] = '{1'b0, 22'h3FFFFF, 16'hFFFF, 0, 1'b1, 22'h3FFFFF, 16'hFFFF};
        vecs[2] = '{1'b0, 22'h000000, 16'h0001, 0, 1'b1, 22'h000000, 16'h0001};
        vecs[3] = '{1'b1, 22'h000020, 16'h1234, 3, 1'b0, 22'h000020, 16'h1234};
        vecs[4] = '{1'b1, 22'h3FFFFF, 16'h8001, 1, 1'b0, 22'h3FFFFF, 16'h8001};
        vecs[5] = '{1'b1, 22'h000000, 16'h0F0F, 5, 1'b0, 22'h000000, 16'h0F0F};

        rst_n           = 1'b1;
        sdram_wr_enable = 1'b0;
        sdram_rd_enable = 1'b0;
        sdram_wr_addr   = '0;
        sdram_wr_data   = '0;
        sdram_rd_addr   = '0;
        cmd_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_data        = '0;
        #2 rst_n = 1'b0;
        #2;
        check_reset_outputs("por");
        do_reset();

        // Single-transaction vectors with a ready downstream
        cmd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v = vecs[i];
            if (!v.is_rd) begin
                sdram_wr_addr   = v.addr;
                sdram_wr_data   = v.data;
                sdram_wr_enable = 1'b1;
                step();
                sdram_wr_enable = 1'b0;
                check("vec_w cmd_valid", 32'(cmd_valid), 32'h1);
                check("vec_w cmd_we",    32'(cmd_we),    32'(v.exp_we));
                check("vec_w cmd_addr",  32'(cmd_addr),  32'(v.exp_addr));
                check("vec_w cmd_wdata", 32'(cmd_wdata), 32'(v.exp_data));
                step();
                check("vec_w one_cycle", 32'(cmd_valid), 32'h0);
            end else begin
                sdram_rd_addr   = v.addr;
                sdram_rd_enable = 1'b1;
                step();
                sdram_rd_enable = 1'b0;
                check("vec_r cmd_valid", 32'(cmd_valid), 32'h1);
                check("vec_r cmd_we",    32'(cmd_we),    32'(v.exp_we));
                check("vec_r cmd_addr",  32'(cmd_addr),  32'(v.exp_addr));
                check("vec_r rd_busy",   32'(rd_busy),   32'h1);
                step();
                check("vec_r cmd_done",  32'(cmd_valid), 32'h0);
                repeat (v.dly - 1) step();
                check("vec_r no_early_rdy", 32'(sdram_rd_rdy), 32'h0);
                rsp_valid = 1'b1;
                rsp_data  = v.data;
                step();
                rsp_valid = 1'b0;
                check("vec_r rd_rdy",    32'(sdram_rd_rdy),  32'h1);
                check("vec_r rd_data",   32'(sdram_rd_data), 32'(v.exp_data));
                check("vec_r busy_clr",  32'(rd_busy),       32'h0);
                step();
                check("vec_r rdy_pulse", 32'(sdram_rd_rdy),  32'h0);
                check("vec_r rd_hold",   32'(sdram_rd_data), 32'(v.exp_data));
            end
            step();
        end

        // FIFO fill with a stalled downstream, fifth write dropped
        do_reset();
        cmd_ready = 1'b0;
        cmd_log.delete();
        for (int i = 0; i < 5; i++) begin
            sdram_wr_enable = 1'b1;
            sdram_wr_addr   = 22'(32'h100 + i);
            sdram_wr_data   = 16'(32'hD000 + i);
            tick();
            if (i == 3) check("fill wr_full_after_4", 32'(wr_full), 32'h1);
        end
        sdram_wr_enable = 1'b0;
        check("fill err",      32'(err),       32'h1);
        check("fill wr_full",  32'(wr_full),   32'h1);
        check("fill cmd_addr", 32'(cmd_addr),  32'h100);
        tick();
        check("fill hold_valid", 32'(cmd_valid), 32'h1);
        check("fill hold_addr",  32'(cmd_addr),  32'h100);
        check("fill hold_data",  32'(cmd_wdata), 32'hD000);
        cmd_ready = 1'b1;
        repeat (16) tick();
        check("fill ncmd", 32'(cmd_log.size()), 32'h4);
        for (int i = 0; i < cmd_log.size(); i++) begin
            check("fill cmd_we",   32'(cmd_log[i].we),   32'h1);
            check("fill cmd_addr", 32'(cmd_log[i].addr), 32'h100 + 32'(i));
            check("fill cmd_data", 32'(cmd_log[i].data), 32'hD000 + 32'(i));
        end
        check("fill drained_full", 32'(wr_full), 32'h0);

        // Simultaneous write and read of the same address
        do_reset();
        cmd_ready = 1'b1;
        cmd_log.delete();
        rdy_n   = 0;
        rsp_dly = 2;
        sdram_wr_addr   = 22'h000030;
        sdram_wr_data   = 16'hBEEF;
        sdram_wr_enable = 1'b1;
        sdram_rd_addr   = 22'h000030;
        sdram_rd_enable = 1'b1;
        cyc = 0;
        tick();
        sdram_wr_enable = 1'b0;
        sdram_rd_enable = 1'b0;
        repeat (12) tick();
        check("wr_rd rdy_count", 32'(rdy_n),    32'h1);
        check("wr_rd rd_data",   32'(rdy_data), 32'hBEEF);
        if (cmd_log.size() > 0) begin
            check("wr_rd first_we",   32'(cmd_log[0].we),   32'h1);
            check("wr_rd first_addr", 32'(cmd_log[0].addr), 32'h30);
            check("wr_rd first_data", 32'(cmd_log[0].data), 32'hBEEF);
        end
`ifdef DREC_PORT_FWD_EN
        check("wr_rd ncmd_fwd", 32'(cmd_log.size()), 32'h1);
        check("wr_rd rdy_cycle", 32'(rdy_cyc), 32'h2);
`else
        check("wr_rd ncmd", 32'(cmd_log.size()), 32'h2);
        if (cmd_log.size() > 1) begin
            check("wr_rd second_we",   32'(cmd_log[1].we),   32'h0);
            check("wr_rd second_addr", 32'(cmd_log[1].addr), 32'h30);
        end
`endif

        // Reset while waiting for read data, then a stale response
        do_reset();
        cmd_ready = 1'b1;
        rsp_dly   = 50;
        sdram_rd_addr   = 22'h000040;
        sdram_rd_enable = 1'b1;
        tick();
        sdram_rd_enable = 1'b0;
        tick();
        check("rst_mid busy_before", 32'(rd_busy), 32'h1);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("rst_mid");
        rsp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 16'h5555;
        step();
        step();
        rsp_valid = 1'b0;
        check("rst_mid no_rdy",   32'(sdram_rd_rdy),  32'h0);
        check("rst_mid rd_data",  32'(sdram_rd_data), 32'h0);
        check("rst_mid cmd",      32'(cmd_valid),     32'h0);
        check("rst_mid busy",     32'(rd_busy),       32'h0);
        step();
        check("rst_mid no_rdy_late", 32'(sdram_rd_rdy), 32'h0);

        // Second read while one is outstanding
        do_reset();
        cmd_ready = 1'b1;
        cmd_log.delete();
        rdy_n   = 0;
        rsp_dly = 2;
        mem[22'h000050] = 16'h7777;
        sdram_rd_addr   = 22'h000050;
        sdram_rd_enable = 1'b1;
        tick();
        sdram_rd_addr   = 22'h000060;
        tick();
        sdram_rd_enable = 1'b0;
        check("rd_busy_rd err", 32'(err), 32'h1);
        repeat (10) tick();
        check("rd_busy_rd rdy_count", 32'(rdy_n),          32'h1);
        check("rd_busy_rd rd_data",   32'(rdy_data),       32'h7777);
        check("rd_busy_rd ncmd",      32'(cmd_log.size()), 32'h1);
        if (cmd_log.size() > 0) begin
            check("rd_busy_rd cmd_addr", 32'(cmd_log[0].addr), 32'h50);
        end
        check("rd_busy_rd err_sticky", 32'(err), 32'h1);

        // Randomised traffic against the reference model
        do_reset();
        spur_en = 1'b1;
        cmd_log.delete();
        mem.delete();
        ref_mem.delete();
        wq.delete();
        exp_rd.delete();
        last_rd = '0;
        for (int c = 0; c < 3000; c++) begin
            rnd_cycle(1'b1);
        end
        for (int c = 0; c < 400; c++) begin
            if (wq.size() == 0 && exp_rd.size() == 0 && rsp_cnt == 0) break;
            rnd_cycle(1'b0);
        end
        check("rnd writes_left", 32'(wq.size()),     32'h0);
        check("rnd reads_left",  32'(exp_rd.size()), 32'h0);
        check("rnd err",         32'(err),           32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
